// File: rtl/class_vote_accum.sv
// class_vote_accum: majority vote over WINDOW classifier results per window.
// Ports: clk, rst (sync, active-high), in_valid/in_class/in_ready upstream,
// out_valid/out_ready/out_class/out_votes downstream.
// Optional out_tie output is present when VOTE_TIE_FLAG_EN is defined.
module class_vote_accum #(
  parameter  int WINDOW = 8,
  parameter  int CW     = 2,
  localparam int NC     = 1 << CW,
  localparam int CNTW   = $clog2(WINDOW + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [CW-1:0]   in_class,
  output logic            in_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CW-1:0]   out_class,
`ifdef VOTE_TIE_FLAG_EN
  output logic            out_tie,
`endif
  output logic [CNTW-1:0] out_votes
);

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    DECIDE = 2'd1,
    REPORT = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [CNTW-1:0] cnt [NC];
  logic [CNTW-1:0] samp;
  logic            accept;
  logic            last;
  logic            done;
  logic [CW-1:0]   best_cls;
  logic [CNTW-1:0] best_cnt;

  assign accept = in_valid && in_ready;
  assign last   = (samp == CNTW'(WINDOW - 1));
  assign done   = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= ACCUM;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ACCUM:   if (accept && last) state_nx = DECIDE;
      DECIDE:  state_nx = REPORT;
      REPORT:  if (out_ready) state_nx = ACCUM;
      default: state_nx = ACCUM;
    endcase
  end

  always_comb begin
    in_ready  = (state == ACCUM);
    out_valid = (state == REPORT);
  end

  always_ff @(posedge clk) begin
    if (rst || done) begin
      for (int i = 0; i < NC; i++) cnt[i] <= '0;
      samp <= '0;
    end else if (accept) begin
      cnt[in_class] <= cnt[in_class] + 1'b1;
      samp          <= samp + 1'b1;
    end
  end

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    best_cls = '0;
    best_cnt = cnt[0];
    for (int i = 1; i < NC; i++) begin
      if (cnt[i] > best_cnt) begin
        best_cls = CW'(i);
        best_cnt = cnt[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_class <= '0;
      out_votes <= '0;
    end else if (state == DECIDE) begin
      out_class <= best_cls;
      out_votes <= best_cnt;
    end
  end

`ifdef VOTE_TIE_FLAG_EN
  logic tie;

  always_comb begin
    tie = 1'b0;
    for (int i = 0; i < NC; i++) begin
      if (CW'(i) != best_cls && cnt[i] == best_cnt) tie = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                  out_tie <= 1'b0;
    else if (state == DECIDE) out_tie <= tie;
  end
`endif

endmodule

// File: tb/tb_class_vote_accum.sv
// tb_class_vote_accum: drives a WINDOW=8 and a WINDOW=1 instance with the
// same stimulus and compares both against a queue-based vote model.
module tb_class_vote_accum;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [1:0] in_class;
  logic       out_ready;

  logic       rdy0, vld0, rdy1, vld1;
  logic [1:0] cls0, cls1;
  logic [3:0] vts0;
  logic [0:0] vts1;
`ifdef VOTE_TIE_FLAG_EN
  logic       tie0, tie1;
`endif

  always #5 clk = ~clk;

  class_vote_accum #(.WINDOW(8), .CW(2)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_class  (in_class),
    .in_ready  (rdy0),
    .out_valid (vld0),
    .out_ready (out_ready),
    .out_class (cls0),
`ifdef VOTE_TIE_FLAG_EN
    .out_tie   (tie0),
`endif
    .out_votes (vts0)
  );

  class_vote_accum #(.WINDOW(1), .CW(2)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_class  (in_class),
    .in_ready  (rdy1),
    .out_valid (vld1),
    .out_ready (out_ready),
    .out_class (cls1),
`ifdef VOTE_TIE_FLAG_EN
    .out_tie   (tie1),
`endif
    .out_votes (vts1)
  );

  int checks   = 0;
  int failures = 0;
  bit live     = 0;

  int q [2][$];
  bit dec [2];
  bit rv  [2];
  int rc  [2];
  int rvt [2];
  int rti [2];
  int win [2] = '{8, 1};

  task automatic check(string tag, int got, int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_edge(int k);
    int h [4];
    int n;
    if (rst) begin
      q[k].delete();
      dec[k] = 0;
      rv[k]  = 0;
      rc[k]  = 0;
      rvt[k] = 0;
      rti[k] = 0;
    end else if (dec[k]) begin
      for (int c = 0; c < 4; c++) h[c] = 0;
      for (int i = 0; i < q[k].size(); i++) h[q[k][i]]++;
      rc[k]  = 0;
      rvt[k] = h[0];
      for (int c = 1; c < 4; c++)
        if (h[c] > rvt[k]) begin
          rc[k]  = c;
          rvt[k] = h[c];
        end
      n = 0;
      for (int c = 0; c < 4; c++) if (h[c] == rvt[k]) n++;
      rti[k] = (n > 1) ? 1 : 0;
      rv[k]  = 1;
      dec[k] = 0;
    end else if (rv[k]) begin
      if (out_ready) begin
        rv[k] = 0;
        q[k].delete();
      end
    end else if (in_valid) begin
      q[k].push_back(int'(in_class));
      if (q[k].size() == win[k]) dec[k] = 1;
    end
  endfunction

  task automatic compare();
    int er, ev;
    for (int k = 0; k < 2; k++) begin
      er = (!dec[k] && !rv[k]) ? 1 : 0;
      ev = rv[k] ? 1 : 0;
      check($sformatf("w%0d_in_ready", win[k]),
            int'(k == 0 ? rdy0 : rdy1), er);
      check($sformatf("w%0d_out_valid", win[k]),
            int'(k == 0 ? vld0 : vld1), ev);
      check($sformatf("w%0d_out_class", win[k]),
            int'(k == 0 ? cls0 : cls1), rc[k]);
      check($sformatf("w%0d_out_votes", win[k]),
            (k == 0) ? int'(vts0) : int'(vts1), rvt[k]);
`ifdef VOTE_TIE_FLAG_EN
      check($sformatf("w%0d_out_tie", win[k]),
            int'(k == 0 ? tie0 : tie1), rti[k]);
`endif
    end
  endtask

  task automatic step(bit v, int c, bit ordy, bit rs);
    @(negedge clk);
    if (live) compare();
    in_valid  = v;
    in_class  = 2'(c);
    out_ready = ordy;
    rst       = rs;
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    live = 1;
  endtask

  task automatic idle(int n, bit ordy);
    for (int i = 0; i < n; i++) step(0, 0, ordy, 0);
  endtask

  int s31 [8] = '{1, 1, 0, 1, 0, 1, 1, 0};
  int s32 [8] = '{0, 1, 1, 0, 1, 0, 0, 1};

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_class  = 2'd0;
    out_ready = 1'b0;
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    idle(2, 1);

    foreach (s31[i]) step(1, s31[i], 1, 0);
    idle(4, 1);

    foreach (s32[i]) step(1, s32[i], 1, 0);
    idle(4, 1);

    for (int i = 0; i < 8; i++) step(1, i % 4, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 2, 0, 0);
    step(1, 2, 1, 0);
    for (int i = 0; i < 8; i++) step(1, 1, 1, 0);
    idle(4, 1);

    for (int i = 0; i < 5; i++) step(1, 2, 1, 0);
    step(1, 2, 1, 1);
    for (int i = 0; i < 8; i++) step(1, (i < 3) ? 3 : 0, 1, 0);
    idle(4, 1);

    for (int i = 0; i < 16; i++) step(i % 2 == 0, 3, 1, 0);
    idle(4, 1);

    step(1, 2, 1, 0);
    step(1, 0, 1, 0);
    idle(4, 1);

    for (int i = 0; i < 4000; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3),
           $urandom_range(0, 2) != 0, $urandom_range(0, 299) == 0);
    idle(2, 1);
    @(negedge clk);
    compare();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/class_vote_accum.md
CLASS_VOTE_ACCUM -- requirements
Module: class_vote_accum

Interface
REQ-001 SHALL have parameter WINDOW, default 8, meaning number of classifier results per vote window (legal 1..255).
REQ-002 SHALL have parameter CW, default 2, meaning class-label width; number of classes NC = 2^CW.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream classifier result present.
REQ-006 SHALL have port in_class  input  CW  class label from the decision-tree output (out of top).
REQ-007 SHALL have port in_ready  output  1  block accepts a result this cycle.
REQ-008 SHALL have port out_valid  output  1  vote result available.
REQ-009 SHALL have port out_ready  input  1  downstream consumes result.
REQ-010 SHALL have port out_class  output  CW  majority class of completed window.
REQ-011 SHALL have port out_votes  output  CNTW  vote count of out_class; CNTW = clog2(WINDOW+1).

Function
REQ-012 SHALL keep NC per-class counters (CNTW bits each) and a sample counter (CNTW bits).
REQ-013 SHALL implement FSM states ACCUM, DECIDE, REPORT.
REQ-014 In ACCUM: in_ready=1; in_valid&&in_ready is an accept; accept increments counter[in_class] and sample counter by 1.
REQ-015 ACCUM->DECIDE on the accept that brings sample counter to WINDOW; otherwise stay in ACCUM.
REQ-016 In DECIDE (exactly one cycle): in_ready=0; argmax of counters registered into out_class/out_votes at end of cycle; next state REPORT.
REQ-017 Argmax tie SHALL resolve to the lowest class index.
REQ-018 In REPORT: in_ready=0, out_valid=1; out_class/out_votes held stable until handshake.
REQ-019 out_valid&&out_ready in REPORT SHALL clear all class counters and sample counter and return to ACCUM (in_ready=1 next cycle).
REQ-020 out_valid without out_ready SHALL hold indefinitely; no input accepted meanwhile (backpressure to upstream).
REQ-021 Latency: last accept at edge k -> out_valid high from edge k+2 (one DECIDE cycle).
REQ-022 Throughput: one window per WINDOW+2 cycles minimum with out_ready tied high.
REQ-023 in_class values never saturate counters: sum of counters equals sample counter <= WINDOW at all times.
REQ-024 in_valid low cycles SHALL not change any counter (gaps allowed anywhere in window).
REQ-025 WINDOW=1: each accept goes directly to DECIDE; out_votes = 1.

Reset
REQ-026 rst high at a rising edge SHALL force state ACCUM, all counters 0, out_class 0, out_votes 0, out_valid 0; in_ready 1 in the cycle after reset release.
REQ-027 rst SHALL override any simultaneous accept or output handshake; partially accumulated window discarded.
REQ-028 rst during REPORT SHALL drop the pending result (out_valid 0 next cycle, never re-presented).

Configuration
REQ-029 Macro VOTE_TIE_FLAG_EN: when defined, SHALL add output out_tie (1 bit), registered in DECIDE, =1 when another class has the same count as out_class, held in REPORT, reset 0.
REQ-030 Without VOTE_TIE_FLAG_EN: no out_tie port, no tie-compare logic; all other behaviour identical.

Verification
REQ-031 WINDOW=8, feed 1,1,0,1,0,1,1,0 back-to-back, out_ready=1 -> out_valid 2 cycles after last accept, out_class=1, out_votes=5, in_ready low 2 cycles.
REQ-032 WINDOW=8, four 0s and four 1s -> out_class=0, out_votes=4, out_tie=1 (macro defined).
REQ-033 Result pending, out_ready=0 for 10 cycles with in_valid=1 -> in_ready=0, outputs stable, no counter change; raise out_ready -> single handshake, next window starts from zero.
REQ-034 Assert rst after 5 accepts -> next window needs full 8 accepts; result reflects only post-reset samples.
REQ-035 in_valid toggling 1/0 every cycle, WINDOW=8, all class 3 -> out_valid after 8 accepts (edge 15+2), out_class=3, out_votes=8.
REQ-036 WINDOW=1, stream 2,0 with out_ready=1 -> two results: class 2 then class 0, each out_votes=1, spaced 3 cycles.
